// File: rtl/horiz_sweep_ctrl_if.sv
// Handshake bundle between the horizontal sweep sequencer and its
// neighbours: sweep request and light samples in, servo command and
// peak-light results out.
interface horiz_sweep_ctrl_if #(
    parameter int POS_W   = 8,
    parameter int LIGHT_W = 12
);
    logic               START;
    logic               CNT_L;
    logic [LIGHT_W-1:0] LIGHT;
    logic               LIGHT_VALID;
    logic               HS;
    logic [POS_W-1:0]   POS;
    logic [POS_W-1:0]   MAX_POS;
    logic [LIGHT_W-1:0] MAX_LIGHT;
    logic               BUSY;
    logic               DONE;

    // Environment side: requests sweeps and supplies counter flag and light.
    modport master (
        output START, CNT_L, LIGHT, LIGHT_VALID,
        input  HS, POS, MAX_POS, MAX_LIGHT, BUSY, DONE
    );

    // Sequencer side.
    modport slave (
        input  START, CNT_L, LIGHT, LIGHT_VALID,
        output HS, POS, MAX_POS, MAX_LIGHT, BUSY, DONE
    );
endinterface

// File: rtl/horiz_sweep_ctrl.sv
// Horizontal-axis sweep sequencer for the solar tracker. Homes the servo,
// steps it towards the end stop while tracking the brightest position,
// then returns to that position and holds it.
module horiz_sweep_ctrl #(
    parameter int POS_W    = 8,
    parameter int LIGHT_W  = 12,
    parameter int POS_MIN  = 0,
    parameter int POS_MAX  = 180,
    parameter int STEP_DIV = 100000,
    parameter int SETTLE   = 50000
) (
    input  logic              CLK,
    input  logic              RST_N,
    horiz_sweep_ctrl_if.slave bus
);

    localparam int MAX_DIV = (STEP_DIV > SETTLE) ? STEP_DIV : SETTLE;
    localparam int CNT_W   = $clog2(MAX_DIV + 1);

    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [POS_W-1:0] POS_MIN_V   = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] POS_MAX_V   = POS_W'(POS_MAX);

    typedef enum logic [2:0] {
        IDLE,
        HOME,
        SWEEP,
        GOTO_MAX,
        HOLD
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   step_cnt;
    logic [CNT_W-1:0]   settle_cnt;
    logic               seen_cnt;
    logic               hs;
    logic [POS_W-1:0]   pos;
    logic [POS_W-1:0]   max_pos;
    logic [LIGHT_W-1:0] max_light;
    logic               busy;
    logic               done;

    logic               step_wrap;
    logic               light_win;
    logic [POS_W-1:0]   cap_pos;
    logic               sweep_exit;

    // Sweep-cycle decisions: step wrap, new peak, and the exit condition
    // (counter flag fell after being seen, or end stop reached on a wrap).
    always_comb begin
        step_wrap  = (step_cnt == STEP_LAST);
        light_win  = bus.LIGHT_VALID && (bus.LIGHT > max_light);
        cap_pos    = light_win ? pos : max_pos;
        sweep_exit = (seen_cnt && !bus.CNT_L) ||
                     ((pos == POS_MAX_V) && step_wrap);
    end

    // Main sequencer: single registered FSM driving every output.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            step_cnt   <= '0;
            settle_cnt <= '0;
            seen_cnt   <= 1'b0;
            hs         <= 1'b0;
            pos        <= POS_MIN_V;
            max_pos    <= POS_MIN_V;
            max_light  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (bus.START) begin
                        state      <= HOME;
                        pos        <= POS_MIN_V;
                        max_pos    <= POS_MIN_V;
                        max_light  <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                HOME: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state    <= SWEEP;
                        hs       <= 1'b1;
                        step_cnt <= '0;
                        seen_cnt <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                SWEEP: begin
                    if (light_win) begin
                        max_light <= bus.LIGHT;
                        max_pos   <= pos;
                    end
                    seen_cnt <= seen_cnt | bus.CNT_L;
                    if (sweep_exit) begin
                        state      <= GOTO_MAX;
                        hs         <= 1'b0;
                        pos        <= cap_pos;
                        settle_cnt <= '0;
                    end else begin
                        step_cnt <= step_wrap ? '0 : step_cnt + CNT_W'(1);
                        if (step_wrap && (pos < POS_MAX_V)) begin
                            pos <= pos + POS_W'(1);
                        end
                    end
                end
                GOTO_MAX: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= HOLD;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.HS        = hs;
    assign bus.POS       = pos;
    assign bus.MAX_POS   = max_pos;
    assign bus.MAX_LIGHT = max_light;
    assign bus.BUSY      = busy;
    assign bus.DONE      = done;

endmodule

// File: tb/tb_horiz_sweep_ctrl.sv
// Directed bench for horiz_sweep_ctrl with a short step period, short
// settle time and a 10-degree end stop so whole sweeps fit in a few
// hundred cycles.
module tb_horiz_sweep_ctrl;

    localparam int POS_W    = 8;
    localparam int LIGHT_W  = 12;
    localparam int T_MAX    = 10;
    localparam int T_STEP   = 4;
    localparam int T_SETTLE = 3;

    localparam int SC_PEAK   = 0;
    localparam int SC_TIE    = 1;
    localparam int SC_LAG    = 2;
    localparam int SC_SAFETY = 3;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    horiz_sweep_ctrl_if #(.POS_W(POS_W), .LIGHT_W(LIGHT_W)) bus ();

    horiz_sweep_ctrl #(
        .POS_W   (POS_W),
        .LIGHT_W (LIGHT_W),
        .POS_MIN (0),
        .POS_MAX (T_MAX),
        .STEP_DIV(T_STEP),
        .SETTLE  (T_SETTLE)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    // Free-running 10-unit clock.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic cnt_l,
                                 input int light, input logic valid);
        bus.START       = start;
        bus.CNT_L       = cnt_l;
        bus.LIGHT       = LIGHT_W'(light);
        bus.LIGHT_VALID = valid;
        @(posedge CLK);
        #1;
    endtask

    function automatic int lightFor(input int scen, input int p);
        case (scen)
            SC_PEAK:   return (p <= 6) ? 100 + 10 * p : 160 - 10 * (p - 6);
            SC_TIE:    return (p == 3 || p == 7) ? 500 : 50;
            SC_SAFETY: return 10 * p + 1;
            default:   return 0;
        endcase
    endfunction

    function automatic logic cntFor(input int scen, input int k, input int p);
        case (scen)
            SC_PEAK, SC_TIE: return (p >= 9) ? 1'b0 : 1'b1;
            SC_LAG:          return (k == 0) ? 1'b0 : ((p >= 2) ? 1'b0 : 1'b1);
            default:         return 1'b1;
        endcase
    endfunction

    // Pulse START and walk through the three HOME cycles.
    task automatic startSweep();
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        checkOutput("busy_after_start", bus.BUSY, 1);
        checkOutput("max_light_cleared", bus.MAX_LIGHT, 0);
        checkOutput("max_pos_cleared", bus.MAX_POS, 0);
        checkOutput("pos_homed", bus.POS, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b0);
            checkOutput("hs_low_in_home", bus.HS, 0);
        end
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("hs_high_after_home", bus.HS, 1);
    endtask

    // Run a sweep through its exit cycle, then the return and DONE pulse.
    task automatic sweepRun(input int scen, input int exit_k,
                            input int exp_mpos, input int exp_mlight);
        for (int k = 0; k <= exit_k; k++) begin
            int p;
            p = (k / T_STEP > T_MAX) ? T_MAX : k / T_STEP;
            checkOutput("sweep_hs", bus.HS, 1);
            checkOutput("sweep_pos", bus.POS, p);
            applyStimulus(1'b0, cntFor(scen, k, p), lightFor(scen, p),
                          (scen != SC_LAG));
        end
        checkOutput("exit_hs", bus.HS, 0);
        checkOutput("exit_pos", bus.POS, exp_mpos);
        checkOutput("exit_max_pos", bus.MAX_POS, exp_mpos);
        checkOutput("exit_max_light", bus.MAX_LIGHT, exp_mlight);
        checkOutput("exit_busy", bus.BUSY, 1);
        checkOutput("exit_done", bus.DONE, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b0);
            checkOutput("settle_done_low", bus.DONE, 0);
            checkOutput("settle_busy", bus.BUSY, 1);
        end
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("done_pulse", bus.DONE, 1);
        checkOutput("hold_busy", bus.BUSY, 0);
        checkOutput("hold_pos", bus.POS, exp_mpos);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("done_one_cycle", bus.DONE, 0);
        checkOutput("hold_hs", bus.HS, 0);
        checkOutput("hold_pos_stays", bus.POS, exp_mpos);
    endtask

    // Test sequence.
    initial begin
        RST_N           = 1'b0;
        bus.START       = 1'b0;
        bus.CNT_L       = 1'b0;
        bus.LIGHT       = '0;
        bus.LIGHT_VALID = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        RST_N = 1'b1;

        checkOutput("reset_hs", bus.HS, 0);
        checkOutput("reset_pos", bus.POS, 0);
        checkOutput("reset_max_pos", bus.MAX_POS, 0);
        checkOutput("reset_max_light", bus.MAX_LIGHT, 0);
        checkOutput("reset_busy", bus.BUSY, 0);
        checkOutput("reset_done", bus.DONE, 0);

        $display("[TB] peak capture sweep");
        startSweep();
        sweepRun(SC_PEAK, 36, 6, 160);

        $display("[TB] tie rule sweep");
        startSweep();
        sweepRun(SC_TIE, 36, 3, 500);

        $display("[TB] counter lag sweep");
        startSweep();
        sweepRun(SC_LAG, 8, 0, 0);

        $display("[TB] end-stop safety sweep");
        startSweep();
        sweepRun(SC_SAFETY, 43, 10, 101);

        $display("[TB] START during sweep, then async reset");
        startSweep();
        for (int k = 0; k < 20; k++) begin
            checkOutput("robust_hs", bus.HS, 1);
            checkOutput("robust_pos", bus.POS, k / T_STEP);
            applyStimulus(k == 10, 1'b1, 0, 1'b0);
        end
        checkOutput("robust_pos_at_5", bus.POS, 5);
        checkOutput("robust_busy", bus.BUSY, 1);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("async_rst_pos", bus.POS, 0);
        checkOutput("async_rst_hs", bus.HS, 0);
        checkOutput("async_rst_busy", bus.BUSY, 0);
        applyStimulus(1'b0, 1'b1, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 0, 1'b0);
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 0, 1'b0);
            checkOutput("post_rst_busy", bus.BUSY, 0);
            checkOutput("post_rst_hs", bus.HS, 0);
            checkOutput("post_rst_pos", bus.POS, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
